// File: rtl/lupdate_pkg.sv
// Shared constants for the beacon-update filter: stream tags, FSM encoding,
// PTP header match values and word/field positions.
package lupdate_pkg;

  localparam int unsigned TAG_HI = 133;
  localparam int unsigned TAG_LO = 132;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_FWD   = 3'd2;
  localparam logic [2:0] ST_PARSE = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  localparam logic [47:0] CNC_MAC   = 48'h010203040506;
  localparam logic [15:0] PTP_ETYPE = 16'h88f7;

  localparam logic [3:0] WORD_HDR = 4'd2;
  localparam logic [3:0] WORD_CFG = 4'd6;
  localparam logic [3:0] WORD_MAX = 4'hf;

  localparam int unsigned DMAC_LSB  = 80;
  localparam int unsigned SMAC_LSB  = 32;
  localparam int unsigned ETYPE_LSB = 16;
  localparam int unsigned MSG_LSB   = 8;
  localparam int unsigned LMID_LSB  = 80;
  localparam int unsigned DIR_BIT   = 79;
  localparam int unsigned TOKEN_LSB = 32;

  typedef struct packed {
    logic         wr;
    logic [133:0] data;
    logic         vwr;
    logic         valid;
  } lu_beat_t;

  function automatic logic is_update(input logic [127:0] p,
                                     input logic [47:0]  local_mac,
                                     input logic [3:0]   msg_type);
    return (p[DMAC_LSB +: 48] == local_mac) &&
           (p[SMAC_LSB +: 48] == CNC_MAC) &&
           (p[ETYPE_LSB +: 16] == PTP_ETYPE) &&
           (p[MSG_LSB +: 4] == msg_type);
  endfunction

endpackage

// File: rtl/lupdate_delay3.sv
// Three-stage delay line for the forwarded stream; each stage carries its own
// word and packet-valid strobes so words can be retracted or re-flagged in flight.
module lu_delay3
  import lupdate_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  lu_beat_t beat_i,
  input  logic     kill_i,
  input  logic     mark_i,
  output lu_beat_t beat_o
);

  lu_beat_t s1_q, s2_q, s3_q;
  lu_beat_t s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = beat_i;
    s2_d = s1_q;
    s3_d = s2_q;
    // Truncation flag rides on the youngest in-flight word, or goes out alone.
    if (mark_i) begin
      if (s1_q.wr) begin
        s2_d.vwr   = 1'b1;
        s2_d.valid = 1'b0;
      end else begin
        s3_d.vwr   = 1'b1;
        s3_d.valid = 1'b0;
      end
    end
    if (kill_i) begin
      s1_d.wr = 1'b0; s1_d.vwr = 1'b0; s1_d.valid = 1'b0;
      s2_d.wr = 1'b0; s2_d.vwr = 1'b0; s2_d.valid = 1'b0;
      s3_d.wr = 1'b0; s3_d.vwr = 1'b0; s3_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign beat_o = s3_q;

endmodule

// File: rtl/lupdate.sv
// Forwards non-update packets through a 3-word delay line with the module id
// stamped into word 0, and absorbs beacon-update packets into config registers.
//
// state | meaning
// IDLE  | between packets, waiting for a head
// HDR   | words 0..2 in flight, packet class not yet known
// FWD   | ordinary packet, forwarding to the tail
// PARSE | update packet, swallowing words and capturing word 6
// DROP  | stray words outside a packet, ignored until the next head
module lupdate
  import lupdate_pkg::*;
#(
  parameter logic [7:0] LMID       = 8'd12,
  parameter logic [3:0] MSG_UPDATE = 4'hd
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_lu_data_wr,
  input  logic [133:0] in_lu_data,
  input  logic         in_lu_data_valid,
  input  logic         in_lu_data_valid_wr,
  input  logic [47:0]  in_local_mac_id,
  output logic         out_lu_data_wr,
  output logic [133:0] out_lu_data,
  output logic         out_lu_data_valid,
  output logic         out_lu_data_valid_wr,
  output logic [47:0]  direct_mac_addr,
  output logic         direction,
  output logic [31:0]  token_bucket_para,
  output logic         beacon_update_master,
  output logic [31:0]  update_cnt,
  output logic [31:0]  discard_cnt
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        cap_q, cap_d;
  logic [47:0] sh_mac_q, sh_mac_d;
  logic        sh_dir_q, sh_dir_d;
  logic [31:0] sh_tok_q, sh_tok_d;

  logic [47:0] mac_q;
  logic        dir_q;
  logic [31:0] tok_q;
  logic        beacon_q;
  logic [31:0] upd_cnt_q;
  logic [31:0] disc_cnt_q;

  logic         fwd, kill, mark, commit, discard;
  logic [1:0]   tag;
  logic         is_head, is_tail, is_body, hdr_upd;
  logic [127:0] payload;
  lu_beat_t     beat_in, beat_out;

  assign tag     = in_lu_data[TAG_HI:TAG_LO];
  assign payload = in_lu_data[127:0];
  assign is_head = (tag == TAG_HEAD);
  assign is_tail = (tag == TAG_TAIL);
  assign is_body = (tag == TAG_MID) || is_tail;
  assign hdr_upd = is_update(payload, in_local_mac_id, MSG_UPDATE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    sh_mac_d = sh_mac_q;
    sh_dir_d = sh_dir_q;
    sh_tok_d = sh_tok_q;
    fwd      = 1'b0;
    kill     = 1'b0;
    mark     = 1'b0;
    commit   = 1'b0;
    discard  = 1'b0;
    if (in_lu_data_wr) begin
      if (is_head) begin
        // A head always starts a fresh packet, closing whatever was open.
        mark    = (state_q == ST_HDR) || (state_q == ST_FWD);
        discard = (state_q == ST_PARSE);
        fwd     = 1'b1;
        state_d = ST_HDR;
        idx_d   = 4'd1;
        cap_d   = 1'b0;
      end else begin
        if (idx_q != WORD_MAX) idx_d = idx_q + 4'd1;
        case (state_q)
          ST_HDR: begin
            if (idx_q == WORD_HDR && hdr_upd) begin
              kill = 1'b1;
              if (is_tail) begin
                discard = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_PARSE;
              end
            end else begin
              fwd = 1'b1;
              if (is_tail) state_d = ST_IDLE;
              else if (idx_q == WORD_HDR) state_d = ST_FWD;
            end
          end
          ST_FWD: begin
            fwd = 1'b1;
            if (is_tail) state_d = ST_IDLE;
          end
          ST_PARSE: begin
            if (idx_q == WORD_CFG) begin
              cap_d    = 1'b1;
              sh_mac_d = payload[DMAC_LSB +: 48];
              sh_dir_d = payload[DIR_BIT];
              sh_tok_d = payload[TOKEN_LSB +: 32];
            end
            if (is_tail) begin
              state_d = ST_IDLE;
              if (in_lu_data_valid && (cap_q || idx_q == WORD_CFG)) commit = 1'b1;
              else discard = 1'b1;
            end
          end
          default: begin
            if (is_body) state_d = ST_DROP;
          end
        endcase
      end
    end
  end

  always_comb begin
    beat_in.wr    = fwd;
    beat_in.data  = in_lu_data;
    beat_in.vwr   = fwd & in_lu_data_valid_wr;
    beat_in.valid = fwd & in_lu_data_valid_wr & in_lu_data_valid;
    if (is_head) beat_in.data[LMID_LSB +: 8] = LMID;
  end

  lu_delay3 u_delay (
    .clk_i  (clk),
    .rst_i  (rst),
    .beat_i (beat_in),
    .kill_i (kill),
    .mark_i (mark),
    .beat_o (beat_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cap_q      <= 1'b0;
      sh_mac_q   <= '0;
      sh_dir_q   <= 1'b0;
      sh_tok_q   <= '0;
      mac_q      <= '0;
      dir_q      <= 1'b0;
      tok_q      <= '0;
      beacon_q   <= 1'b0;
      upd_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      sh_mac_q <= sh_mac_d;
      sh_dir_q <= sh_dir_d;
      sh_tok_q <= sh_tok_d;
      // sh_*_d already holds word 6 when the tail is word 6 itself.
      if (commit) begin
        mac_q     <= sh_mac_d;
        dir_q     <= sh_dir_d;
        tok_q     <= sh_tok_d;
        beacon_q  <= ~beacon_q;
        upd_cnt_q <= upd_cnt_q + 32'd1;
      end
      if (discard) disc_cnt_q <= disc_cnt_q + 32'd1;
    end
  end

  assign out_lu_data_wr       = beat_out.wr;
  assign out_lu_data          = beat_out.data;
  assign out_lu_data_valid    = beat_out.valid;
  assign out_lu_data_valid_wr = beat_out.vwr;
  assign direct_mac_addr      = mac_q;
  assign direction            = dir_q;
  assign token_bucket_para    = tok_q;
  assign beacon_update_master = beacon_q;
  assign update_cnt           = upd_cnt_q;
  assign discard_cnt          = disc_cnt_q;

endmodule

// File: tb/tb_lupdate.sv
// Randomized scoreboard bench for lupdate: packet-level reference model feeds
// an expected-output queue that a negedge monitor drains.
module tb_lupdate;

  localparam logic [47:0] LMAC = 48'h5a5b5c5d5e5f;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_wr, in_valid, in_vwr;
  logic [133:0] in_data;
  logic         out_wr, out_valid, out_vwr;
  logic [133:0] out_data;
  logic [47:0]  direct_mac_addr;
  logic         direction;
  logic [31:0]  token_bucket_para;
  logic         beacon_update_master;
  logic [31:0]  update_cnt, discard_cnt;

  lupdate dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_lu_data_wr        (in_wr),
    .in_lu_data           (in_data),
    .in_lu_data_valid     (in_valid),
    .in_lu_data_valid_wr  (in_vwr),
    .in_local_mac_id      (LMAC),
    .out_lu_data_wr       (out_wr),
    .out_lu_data          (out_data),
    .out_lu_data_valid    (out_valid),
    .out_lu_data_valid_wr (out_vwr),
    .direct_mac_addr      (direct_mac_addr),
    .direction            (direction),
    .token_bucket_para    (token_bucket_para),
    .beacon_update_master (beacon_update_master),
    .update_cnt           (update_cnt),
    .discard_cnt          (discard_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           has_d;
    logic [133:0] d;
    bit           has_v;
    bit           v;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [47:0]  m_mac;
  bit           m_dir;
  logic [31:0]  m_tok;
  bit           m_beacon;
  int unsigned  m_upd, m_disc;
  bit           use_w6 = 1'b0;
  logic [127:0] forced_w6;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst && (out_wr || out_vwr)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out cyc=%0d wr=%b vwr=%b data=%0h", cyc, out_wr, out_vwr, out_data);
      end else begin
        e  = sbq.pop_front();
        ok = (e.has_d == out_wr) && (e.has_v == out_vwr);
        if (e.has_d && (out_data !== e.d || cyc != e.cyc)) ok = 1'b0;
        if (e.has_v && out_valid !== e.v) ok = 1'b0;
        if (!ok) begin
          errors++;
          $display("FAIL out_word actual wr=%b vwr=%b v=%b cyc=%0d data=%0h required wr=%b vwr=%b v=%b cyc=%0d data=%0h",
                   out_wr, out_vwr, out_valid, cyc, out_data, e.has_d, e.has_v, e.v, e.cyc, e.d);
        end
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // An update is recognised purely from the word-2 header fields.
  function automatic bit m_is_update(input logic [127:0] p);
    return p[127:80] == LMAC && p[79:32] == 48'h010203040506 &&
           p[31:16] == 16'h88f7 && p[11:8] == 4'hd;
  endfunction

  // kind: 0 random, 1 update, 2 ethertype 0800, 3 wrong dmac, 4 wrong smac, 5 wrong msgtype
  function automatic logic [127:0] hdr_word(input int kind);
    logic [127:0] p;
    p = rnd128();
    if (kind != 0) begin
      p[127:80] = LMAC;
      p[79:32]  = 48'h010203040506;
      p[31:16]  = 16'h88f7;
      p[11:8]   = 4'hd;
    end
    case (kind)
      2: p[31:16] = 16'h0800;
      3: p[127:80] = ~LMAC;
      4: p[79:32] = 48'h010203040507;
      5: p[11:8] = 4'hc;
      default: ;
    endcase
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_wr = 1'b0; in_vwr = 1'b0; in_valid = 1'b0; in_data = '0;
    end
  endtask

  task automatic drive(input logic [133:0] w, input bit vwr, input bit v);
    @(posedge clk); #1;
    in_wr = 1'b1; in_data = w; in_vwr = vwr; in_valid = vwr & v;
  endtask

  task automatic check_cfg();
    chk("direct_mac_addr", 128'(direct_mac_addr), 128'(m_mac));
    chk("direction", 128'(direction), 128'(m_dir));
    chk("token_bucket_para", 128'(token_bucket_para), 128'(m_tok));
    chk("beacon_update_master", 128'(beacon_update_master), 128'(m_beacon));
    chk("update_cnt", 128'(update_cnt), 128'(m_upd));
    chk("discard_cnt", 128'(discard_cnt), 128'(m_disc));
  endtask

  task automatic check_all_zero();
    chk("rst_out_wr", 128'(out_wr), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_valid", 128'({out_valid, out_vwr}), 128'(0));
    m_mac = '0; m_dir = 1'b0; m_tok = '0; m_beacon = 1'b0; m_upd = 0; m_disc = 0;
    check_cfg();
  endtask

  // n words; abort=1 means no tail (caller must start the next head with no gap)
  task automatic send(input int n, input int kind, input bit abort, input bit good, input int pregap);
    logic [127:0] p2, cfgw, p;
    logic [133:0] w;
    logic [1:0]   tag;
    bit           upd, is_tail;
    exp_t         e;
    cfgw = use_w6 ? forced_w6 : rnd128();
    p2   = hdr_word(kind);
    upd  = (n >= 3) && m_is_update(p2);
    idle(pregap);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && !upd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      is_tail = !abort && (i == n - 1);
      tag = (i == 0) ? 2'b01 : (is_tail ? 2'b10 : 2'b11);
      p = (i == 2) ? p2 : ((i == 6) ? cfgw : rnd128());
      w = {tag, 4'($urandom_range(0, 15)), p};
      drive(w, is_tail, good);
      if (!upd) begin
        e.has_d = 1'b1;
        e.d     = w;
        if (i == 0) e.d[87:80] = 8'd12;
        e.has_v = is_tail;
        e.v     = is_tail & good;
        e.cyc   = cyc + 3;
        sbq.push_back(e);
      end
    end
    if (abort && !upd) begin
      e = sbq.pop_back();
      e.has_v = 1'b1;
      e.v     = 1'b0;
      sbq.push_back(e);
    end
    if (upd) begin
      if (!abort && good && n >= 7) begin
        m_mac = cfgw[127:80]; m_dir = cfgw[79]; m_tok = cfgw[63:32];
        m_beacon = ~m_beacon; m_upd++;
      end else begin
        m_disc++;
      end
    end
    if (!abort) begin
      idle(1);
      check_cfg();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, kind;
    bit  abort, good, prev_abort;
    logic [127:0] p;

    rst = 1'b1;
    in_wr = 1'b0; in_vwr = 1'b0; in_valid = 1'b0; in_data = '0;
    idle(3);
    check_all_zero();
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // Plain 8-word packet, ethertype 0800
    send(8, 2, 1'b0, 1'b1, 0);
    idle(4);
    // Update with fixed config word
    use_w6 = 1'b1;
    forced_w6 = {48'h0a0b0c0d0e0f, 1'b1, 15'h0, 32'h00010020, 32'h0};
    send(8, 1, 1'b0, 1'b1, 2);
    use_w6 = 1'b0;
    // Short update, tail at word 4
    send(5, 1, 1'b0, 1'b1, 2);
    // Update whose tail is not good, then a good one
    send(8, 1, 1'b0, 1'b0, 2);
    send(8, 1, 1'b0, 1'b1, 1);
    // Truncated forward at word 5, followed immediately by an intact packet
    send(5, 0, 1'b1, 1'b1, 3);
    send(6, 2, 1'b0, 1'b1, 0);
    // Aborted update, tail-at-word-2 update, tail-is-word-6 update
    send(7, 1, 1'b1, 1'b1, 2);
    send(4, 0, 1'b0, 1'b1, 0);
    send(3, 1, 1'b0, 1'b1, 2);
    send(7, 1, 1'b0, 1'b1, 2);

    prev_abort = 1'b0;
    for (int k = 0; k < 60; k++) begin
      kind  = $urandom_range(0, 5);
      n     = $urandom_range(1, 10);
      abort = ($urandom_range(0, 5) == 0);
      good  = ($urandom_range(0, 4) != 0);
      if (!abort && n < 2) n = 2;
      if (!prev_abort && $urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) drive({2'b11, 4'h0, rnd128()}, 1'b0, 1'b0);
        else drive({2'b10, 4'h0, rnd128()}, 1'b1, 1'b1);
      end
      send(n, kind, abort, good, prev_abort ? 0 : $urandom_range(0, 3));
      prev_abort = abort;
    end
    send(8, 0, 1'b0, 1'b1, 0);

    // Reset pulsed at word 3 of an update
    idle(6);
    p = hdr_word(1);
    drive({2'b01, 4'h0, rnd128()}, 1'b0, 1'b0);
    drive({2'b11, 4'h0, rnd128()}, 1'b0, 1'b0);
    drive({2'b11, 4'h0, p}, 1'b0, 1'b0);
    drive({2'b11, 4'h0, rnd128()}, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; in_wr = 1'b0; in_vwr = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    check_all_zero();
    rst = 1'b0;
    drive({2'b11, 4'h0, rnd128()}, 1'b0, 1'b0);
    drive({2'b11, 4'h0, rnd128()}, 1'b0, 1'b0);
    drive({2'b11, 4'h0, {48'h0a0b0c0d0e0f, 1'b1, 15'h0, 32'h00010020, 32'h0}}, 1'b0, 1'b0);
    drive({2'b10, 4'h0, rnd128()}, 1'b1, 1'b1);
    idle(2);
    check_cfg();
    send(4, 0, 1'b0, 1'b1, 0);

    idle(6);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lupdate.md
LUPDATE -- requirements
Module: lupdate

Interface
REQ-001 Parameter LMID, default 8'd12, module identifier written into metadata word 0 bits [87:80] of forwarded packets.
REQ-002 Parameter MSG_UPDATE, default 4'hd, PTP message type that identifies a beacon update.
REQ-003 Port clk  in  1  single clock; all logic is clocked on the rising edge.
REQ-004 Port rst  in  1  reset, synchronous and active-high.
REQ-005 Port in_lu_data_wr  in  1  input word strobe.
REQ-006 Port in_lu_data  in  134  input word: [133:132] tag (01 head, 11 mid, 10 tail), [127:0] payload.
REQ-007 Ports in_lu_data_valid / in_lu_data_valid_wr  in  1 each  packet-good flag and its strobe, asserted with the tail word.
REQ-008 Port in_local_mac_id  in  48  local MAC address of the node.
REQ-009 Ports out_lu_data_wr / out_lu_data / out_lu_data_valid / out_lu_data_valid_wr  out  1/134/1/1  forwarded stream, same format as the input stream.
REQ-010 Ports direct_mac_addr  out 48; direction  out 1; token_bucket_para  out 32  configuration registers.
REQ-011 Port beacon_update_master  out  1  toggles once per committed update.
REQ-012 Ports update_cnt / discard_cnt  out  32 each  committed-update count and malformed-update count.

Function
REQ-013 Word index k counts from 0 at the head. Word 2 carries: dmac [127:80], smac [79:32], ethertype [31:16], msgtype [11:8].
REQ-014 A packet is an update if, at word 2: dmac == in_local_mac_id, smac == 48'h010203040506, ethertype == 16'h88f7, and msgtype == MSG_UPDATE.
REQ-015 Word 6 of an update carries: direct_mac_addr [127:80], direction [79], token_bucket_para [63:32].
REQ-016 The data path is a 3-word delay line. Every input word of a non-update packet appears on the outputs exactly 3 cycles later, with input gaps preserved. Word 0 bits [87:80] are replaced by LMID.
REQ-017 The FSM has states IDLE, HDR, FWD, PARSE, DROP.
  - IDLE: a head word moves to HDR.
  - HDR: on word 2, go to PARSE if the packet is an update, otherwise go to FWD.
  - FWD: on the tail, go to IDLE.
  - PARSE: capture word 6 into shadow registers; go to IDLE on the tail.
  - DROP: discard words until the next head.
REQ-018 Update packets are never forwarded. out_lu_data_wr stays 0 for all of their words, including the 3 words already held in the delay line.
REQ-019 Commit: on a tail with in_lu_data_valid=1 and word 6 captured, copy the shadow registers to the outputs, toggle beacon_update_master, and increment update_cnt, all on the same edge.
REQ-020 A malformed update (tail before word 6, or tail with valid=0) commits nothing and increments discard_cnt by 1.
REQ-021 A head word arriving while not in IDLE aborts the current packet:
  - an update in progress counts as discard;
  - a forward in progress is truncated, with out_valid=0 emitted as its last word;
  - the new head is processed normally.
REQ-022 Mid/tail words seen in IDLE are ignored and never forwarded.
REQ-023 update_cnt and discard_cnt wrap from 32'hffffffff to 0.
REQ-024 HDR ends at word 2. If the tail arrives before word 2, the packet is forwarded unchanged.

Reset
REQ-025 While rst=1:
  - all outputs are 0, and both counters are 0;
  - the FSM is in IDLE, and the delay line and shadow registers are cleared.
REQ-026 A reset asserted mid-packet discards the partial packet. The remaining words after release are dropped until the next head.

Structure
REQ-027 A shared package holds the tag encodings, state encoding, CNC MAC, PTP ethertype, and word-index/field-position constants.
REQ-028 The 3-word delay line is the sub-module lu_delay3, with its own valid/strobe bits per stage.

Verification
REQ-029 8-word non-update packet (ethertype 16'h0800) -> identical words out 3 cycles later, word 0 [87:80]=LMID, no config change.
REQ-030 Valid update with word 6 = {direct_mac 48'h0a0b0c0d0e0f, direction 1, token 32'h00010020} -> outputs take these values on the tail edge, beacon_update_master toggles, update_cnt=1, no output strobe.
REQ-031 Update with tail at word 4 -> config unchanged, discard_cnt=1, no output strobe.
REQ-032 Update whose tail has valid=0 -> no commit, discard_cnt=1; a following valid update commits normally.
REQ-033 Head arrives at word 5 of a forwarded packet -> truncated packet ends with valid=0 and the new packet is forwarded intact. Separately, rst pulsed at word 3 of an update -> all outputs 0 and no commit.
